// File: rtl/rr_mux_arbiter.sv
// Four-requester round-robin arbiter with a registered data mux on the granted lane.
// Optional RR_ARB_TIMEOUT_EN adds a 16-cycle grant hold limit.
module rr_mux_arbiter #(
    parameter int unsigned DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          req,
    input  logic [4*DATA_W-1:0] din,
    output logic [3:0]          gnt,
    output logic [1:0]          sel,
    output logic [DATA_W-1:0]   y,
    output logic                y_valid
);

    localparam int unsigned N_REQ = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        last;
    logic [1:0]        last_d;
    logic [3:0]        gnt_d;
    logic [1:0]        sel_d;
    logic [DATA_W-1:0] y_d;
    logic              y_valid_d;
    logic [1:0]        win;
    logic [1:0]        idx;
    logic              win_found;
    logic [DATA_W-1:0] lane_sel;
    logic              hold_expired_c;
    logic              release_c;

    // Winner search starts just after the last served requester and wraps.
    always_comb begin
        win_found = 1'b0;
        win       = 2'd0;
        idx       = 2'd0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            idx = 2'(last + 2'(k));
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win       = idx;
            end
        end
    end

    always_comb begin
        lane_sel = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (sel == 2'(i)) begin
                lane_sel = din[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    logic [3:0] hold_cnt;

    // Counts cycles spent in GRANT; zero in the first grant cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= 4'd0;
        end else if (state == GRANT) begin
            hold_cnt <= hold_cnt + 4'd1;
        end else begin
            hold_cnt <= 4'd0;
        end
    end

    assign hold_expired_c = (hold_cnt == 4'd15);
`else
    assign hold_expired_c = 1'b0;
`endif

    assign release_c = !req[sel] || hold_expired_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = GRANT;
            GRANT:   if (release_c) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; y and sel hold unless loaded.
    always_comb begin
        gnt_d     = 4'b0000;
        sel_d     = sel;
        y_d       = y;
        y_valid_d = 1'b0;
        last_d    = last;
        case (state)
            IDLE: begin
                if (win_found) begin
                    gnt_d = 4'b0001 << win;
                    sel_d = win;
                end
            end
            GRANT: begin
                if (release_c) begin
                    last_d = sel;
                end else begin
                    gnt_d     = gnt;
                    y_d       = lane_sel;
                    y_valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt     <= 4'b0000;
            sel     <= 2'd0;
            y       <= '0;
            y_valid <= 1'b0;
            last    <= 2'd3;
        end else begin
            gnt     <= gnt_d;
            sel     <= sel_d;
            y       <= y_d;
            y_valid <= y_valid_d;
            last    <= last_d;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter.
module tb_rr_mux_arbiter;

    localparam int unsigned DATA_W = 8;

    logic                clk;
    logic                rst;
    logic [3:0]          req;
    logic [4*DATA_W-1:0] din;
    logic [3:0]          gnt;
    logic [1:0]          sel;
    logic [DATA_W-1:0]   y;
    logic                y_valid;

    int tests;
    int fails;

    rr_mux_arbiter #(.DATA_W(DATA_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .din     (din),
        .gnt     (gnt),
        .sel     (sel),
        .y       (y),
        .y_valid (y_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b0000;
        din = '0;
        step();
        step();
        tests++;
        if ({gnt, sel, y, y_valid} !== {4'b0000, 2'd0, 8'h00, 1'b0}) begin
            $display("FAIL reset_state: got gnt=%b sel=%0d y=%h v=%b want 0000 0 00 0", gnt, sel, y, y_valid);
            fails++;
        end
        rst = 1'b0;
        step();
        step();
        tests++;
        if (gnt !== 4'b0000 || y_valid !== 1'b0) begin
            $display("FAIL idle_no_req: got gnt=%b v=%b want 0000 0", gnt, y_valid);
            fails++;
        end
    endtask

    task automatic test_rr_order();
        int order [4] = '{1, 2, 3, 0};
        int cur;
        logic [3:0] one_hot;
        logic [3:0] exp_gnt;
        req = 4'b1111;
        step();
        tests++;
        if (gnt !== 4'b0001 || sel !== 2'd0 || y_valid !== 1'b0) begin
            $display("FAIL first_grant: got gnt=%b sel=%0d v=%b want 0001 0 0", gnt, sel, y_valid);
            fails++;
        end
        cur = 0;
        for (int i = 0; i < 4; i++) begin
            one_hot = 4'b0001 << cur;
            req = ~one_hot;
            step();
            tests++;
            if (gnt !== 4'b0000) begin
                $display("FAIL rr_idle_gap_%0d: got gnt=%b want 0000", i, gnt);
                fails++;
            end
            req = 4'b1111;
            step();
            exp_gnt = 4'b0001 << order[i];
            tests++;
            if (gnt !== exp_gnt || sel !== 2'(order[i])) begin
                $display("FAIL rr_grant_%0d: got gnt=%b sel=%0d want %b %0d", i, gnt, sel, exp_gnt, order[i]);
                fails++;
            end
            cur = order[i];
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_data_and_handover();
        din = {8'h33, 8'h22, 8'h11, 8'h00};
        req = 4'b0100;
        step();
        tests++;
        if (gnt !== 4'b0100 || sel !== 2'd2 || y_valid !== 1'b0) begin
            $display("FAIL lane2_grant: got gnt=%b sel=%0d v=%b want 0100 2 0", gnt, sel, y_valid);
            fails++;
        end
        din = {8'h33, 8'hA5, 8'h11, 8'h00};
        step();
        tests++;
        if (y !== 8'hA5 || y_valid !== 1'b1) begin
            $display("FAIL data_a5: got y=%h v=%b want a5 1", y, y_valid);
            fails++;
        end
        din = {8'h33, 8'h3C, 8'h11, 8'h00};
        step();
        tests++;
        if (y !== 8'h3C || y_valid !== 1'b1) begin
            $display("FAIL data_3c: got y=%h v=%b want 3c 1", y, y_valid);
            fails++;
        end
        req = 4'b1011;
        step();
        tests++;
        if (gnt !== 4'b0000 || y_valid !== 1'b0 || y !== 8'h3C) begin
            $display("FAIL release_idle: got gnt=%b v=%b y=%h want 0000 0 3c", gnt, y_valid, y);
            fails++;
        end
        step();
        tests++;
        if (gnt !== 4'b1000 || sel !== 2'd3) begin
            $display("FAIL next_after_2: got gnt=%b sel=%0d want 1000 3", gnt, sel);
            fails++;
        end
    endtask

    task automatic test_no_preempt();
        req = 4'b1111;
        step();
        step();
        tests++;
        if (gnt !== 4'b1000 || y !== 8'h33 || y_valid !== 1'b1) begin
            $display("FAIL no_preempt: got gnt=%b y=%h v=%b want 1000 33 1", gnt, y, y_valid);
            fails++;
        end
        req = 4'b0111;
        step();
        step();
        tests++;
        if (gnt !== 4'b0001 || sel !== 2'd0) begin
            $display("FAIL wrap_3_to_0: got gnt=%b sel=%0d want 0001 0", gnt, sel);
            fails++;
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_reset_mid_grant();
        din = {8'h33, 8'h22, 8'h5A, 8'h00};
        req = 4'b0010;
        step();
        step();
        tests++;
        if (gnt !== 4'b0010 || y !== 8'h5A || y_valid !== 1'b1) begin
            $display("FAIL lane1_hold: got gnt=%b y=%h v=%b want 0010 5a 1", gnt, y, y_valid);
            fails++;
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({gnt, sel, y, y_valid} !== {4'b0000, 2'd0, 8'h00, 1'b0}) begin
            $display("FAIL async_reset: got gnt=%b sel=%0d y=%h v=%b want 0000 0 00 0", gnt, sel, y, y_valid);
            fails++;
        end
        #2 rst = 1'b0;
        step();
        tests++;
        if (gnt !== 4'b0010 || sel !== 2'd1) begin
            $display("FAIL grant_after_reset: got gnt=%b sel=%0d want 0010 1", gnt, sel);
            fails++;
        end
        req = 4'b0000;
        step();
        // Pointer must be back at 3 after reset, so requester 0 beats 3.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b1001;
        step();
        tests++;
        if (gnt !== 4'b0001) begin
            $display("FAIL reset_pointer: got gnt=%b want 0001", gnt);
            fails++;
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_hold_limit();
        int n;
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b0011;
        step();
        n = 0;
        while (gnt === 4'b0001 && n < 40) begin
            n++;
            step();
        end
`ifdef RR_ARB_TIMEOUT_EN
        tests++;
        if (n !== 16) begin
            $display("FAIL timeout_len: got %0d cycles want 16", n);
            fails++;
        end
        tests++;
        if (gnt !== 4'b0000) begin
            $display("FAIL timeout_idle: got gnt=%b want 0000", gnt);
            fails++;
        end
        step();
        tests++;
        if (gnt !== 4'b0010) begin
            $display("FAIL timeout_next: got gnt=%b want 0010", gnt);
            fails++;
        end
`else
        tests++;
        if (n !== 40 || gnt !== 4'b0001) begin
            $display("FAIL hold_forever: got %0d cycles gnt=%b want 40 0001", n, gnt);
            fails++;
        end
`endif
        req = 4'b0000;
        step();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        req = 4'b0000;
        din = '0;
        test_reset();
        test_rr_order();
        test_data_and_handover();
        test_no_preempt();
        test_reset_mid_grant();
        test_hold_limit();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // One-hot-or-zero grant at every sample point.
    always @(negedge clk) begin
        if (!rst && !$onehot0(gnt)) begin
            tests++;
            fails++;
            $display("FAIL gnt_onehot: got gnt=%b want one-hot or zero", gnt);
        end
    end

endmodule
